acs_layer: RTL and testbench

Add-compare-select stage of the rate-1/2, K=7 hard-decision Viterbi decoder. It consumes the packed 2-bit branch metrics produced by the per-state branch-metric units, one trellis step per accepted beat. It updates all path metrics with min-normalization and emits one survivor decision bit per state to the traceback stage under a valid/ready handshake.

---
 rtl/acs_pkg.sv | 36 +++
 rtl/acs_node.sv | 32 +++
 rtl/acs_layer.sv | 141 ++++++++++++++
 tb/tb_acs_layer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/acs_pkg.sv
// acs_pkg: shared definitions for the add-compare-select layer of the
// rate-1/2, K=7 hard-decision Viterbi decoder.
//   N_STATES / S_W : trellis size and state-index width
//   PM_W           : path-metric width (unsigned)
//   BM_W           : branch-metric field width
//   INIT_PM        : starting metric of every state except state 0
//   pm_t           : path-metric type at the default width
//   pred()         : predecessor of a next state
//   sat_add()      : add with clamp at a ceiling
package acs_pkg;

  localparam int N_STATES = 64;
  localparam int S_W      = $clog2(N_STATES);
  localparam int PM_W     = 8;
  localparam int BM_W     = 2;
  localparam int INIT_PM  = 64;

  typedef logic [PM_W-1:0] pm_t;

  // Next state j = {u, s[S_W-1:1]}, so its two predecessors are
  // (j << 1) mod n with the low bit b in {0, 1}.
  function automatic int pred(input int j, input int b, input int n);
    return ((j * 2) % n) | b;
  endfunction

  // Wide add, then clamp to max_v. Callers pass zero-extended operands and
  // the all-ones value of their metric width, so the sum never wraps.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [31:0] s;
    s = a + b;
    return (s > max_v) ? max_v : s;
  endfunction

endpackage

// File: rtl/acs_node.sv
// acs_node: add-compare-select for one next state.
//   pm0, pm1 : metrics of the two predecessors (p0 even, p1 odd)
//   bm0, bm1 : branch metrics from p0 and p1 for this state's input bit
//   sel      : surviving candidate metric, saturated at 2^PM_W-1
//   dec      : 1 when the odd predecessor survives
module acs_node #(
  parameter int PM_W = 8,
  parameter int BM_W = 2
) (
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [BM_W-1:0] bm0,
  input  logic [BM_W-1:0] bm1,
  output logic [PM_W-1:0] sel,
  output logic            dec
);
  import acs_pkg::*;

  localparam logic [31:0] SAT_MAX = (32'd1 << PM_W) - 32'd1;

  logic [PM_W-1:0] c0;
  logic [PM_W-1:0] c1;

  always_comb begin
    c0  = PM_W'(sat_add(32'(pm0), 32'(bm0), SAT_MAX));
    c1  = PM_W'(sat_add(32'(pm1), 32'(bm1), SAT_MAX));
    // Strict compare: equal candidates keep the even predecessor.
    dec = (c1 < c0);
    sel = dec ? c1 : c0;
  end

endmodule

// File: rtl/acs_layer.sv
// acs_layer: one trellis step of add-compare-select per accepted beat, with
// min-normalized path metrics and one survivor bit per state.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : restart from initial metrics (qualified by accept)
//   bm_in                : per source state s, [4s+:2] input-0, [4s+2+:2] input-1
//   in_valid / in_ready  : step input handshake
//   dec                  : survivor decision per next state
//   dec_sof              : word is the first step after a (re)start
//   best_state           : argmin state of the new metrics
//   dec_valid / dec_ready: decision output handshake
// Optional build macro ACS_BEST_STATE_EN: when defined, best_state carries the
// lowest-index argmin of the pre-normalization metrics; otherwise it is 0 and
// only the minimum value is computed.
//
// Handshake: a transfer happens on an edge where valid && ready. in_ready is
// !dec_valid || dec_ready, so a held word blocks new input, and a word taken
// on the same edge a new beat is accepted is replaced without a bubble.
module acs_layer #(
  parameter int N_STATES = acs_pkg::N_STATES,
  parameter int PM_W     = acs_pkg::PM_W,
  parameter int INIT_PM  = acs_pkg::INIT_PM,
  localparam int S_W     = $clog2(N_STATES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*N_STATES-1:0] bm_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N_STATES-1:0]   dec,
  output logic                  dec_sof,
  output logic [S_W-1:0]        best_state,
  output logic                  dec_valid,
  input  logic                  dec_ready
);
  import acs_pkg::*;

  localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);

  logic [PM_W-1:0]     pm      [N_STATES];
  logic [PM_W-1:0]     cur_pm  [N_STATES];
  logic [PM_W-1:0]     sel     [N_STATES];
  logic [PM_W-1:0]     pm_next [N_STATES];
  logic [N_STATES-1:0] dec_c;
  logic [PM_W-1:0]     min_v;
  logic                sof_pending;
  logic                use_init;
  logic                accept;

  assign in_ready = !dec_valid || dec_ready;
  assign accept   = in_valid && in_ready;
  // Reset leaves sof_pending set so the first beat afterwards restarts the
  // trellis even without start.
  assign use_init = start || sof_pending;

  always_comb begin
    for (int j = 0; j < N_STATES; j++) begin
      cur_pm[j] = use_init ? ((j == 0) ? '0 : INIT_V) : pm[j];
    end
  end

  for (genvar j = 0; j < N_STATES; j++) begin : g_node
    localparam int P0 = pred(j, 0, N_STATES);
    localparam int P1 = pred(j, 1, N_STATES);
    localparam int U  = j >> (S_W - 1);
    acs_node #(
      .PM_W (PM_W),
      .BM_W (BM_W)
    ) u_node (
      .pm0 (cur_pm[P0]),
      .pm1 (cur_pm[P1]),
      .bm0 (bm_in[2*BM_W*P0 + BM_W*U +: BM_W]),
      .bm1 (bm_in[2*BM_W*P1 + BM_W*U +: BM_W]),
      .sel (sel[j]),
      .dec (dec_c[j])
    );
  end

`ifdef ACS_BEST_STATE_EN
  logic [S_W-1:0] min_idx;

  // Strict less-than keeps the earliest index on equal metrics.
  always_comb begin
    min_v   = sel[0];
    min_idx = '0;
    for (int j = 1; j < N_STATES; j++) begin
      if (sel[j] < min_v) begin
        min_v   = sel[j];
        min_idx = S_W'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_state <= '0;
    end else if (accept) begin
      best_state <= min_idx;
    end
  end
`else
  always_comb begin
    min_v = sel[0];
    for (int j = 1; j < N_STATES; j++) begin
      if (sel[j] < min_v) min_v = sel[j];
    end
  end

  assign best_state = '0;
`endif

  // Subtracting the minimum keeps the best metric at 0 after every step.
  always_comb begin
    for (int j = 0; j < N_STATES; j++) begin
      pm_next[j] = sel[j] - min_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N_STATES; j++) begin
        pm[j] <= (j == 0) ? '0 : INIT_V;
      end
      dec         <= '0;
      dec_sof     <= 1'b0;
      dec_valid   <= 1'b0;
      sof_pending <= 1'b1;
    end else if (accept) begin
      for (int j = 0; j < N_STATES; j++) begin
        pm[j] <= pm_next[j];
      end
      dec         <= dec_c;
      dec_sof     <= use_init;
      dec_valid   <= 1'b1;
      sof_pending <= 1'b0;
    end else if (dec_ready) begin
      dec_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acs_layer.sv
// tb_acs_layer: directed test of acs_layer with hand-computed expectations.
// A second instance with INIT_PM=255 covers metric saturation.
module tb_acs_layer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [255:0] bm_in;
  logic         in_valid;
  logic         dec_ready;

  logic         in_ready;
  logic [63:0]  dec;
  logic         dec_sof;
  logic [5:0]   best_state;
  logic         dec_valid;

  logic         s_in_ready;
  logic [63:0]  s_dec;
  logic         s_dec_sof;
  logic [5:0]   s_best_state;
  logic         s_dec_valid;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  acs_layer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bm_in      (bm_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dec        (dec),
    .dec_sof    (dec_sof),
    .best_state (best_state),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready)
  );

  acs_layer #(.INIT_PM(255)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bm_in      (bm_in),
    .in_valid   (in_valid),
    .in_ready   (s_in_ready),
    .dec        (s_dec),
    .dec_sof    (s_dec_sof),
    .best_state (s_best_state),
    .dec_valid  (s_dec_valid),
    .dec_ready  (dec_ready)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Present one beat, wait for the edge, sample point is #1 after it.
  task automatic send_beat(input logic st, input logic [255:0] bm);
    in_valid = 1'b1;
    start    = st;
    bm_in    = bm;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  function automatic logic [255:0] put_bm(input logic [255:0] b, input int s,
                                          input int u, input logic [1:0] v);
    b[4*s + 2*u +: 2] = v;
    return b;
  endfunction

  // Expected state after a restart beat with all branch metrics 0.
  task automatic check_zero_restart(input string tag);
    check_val({tag, "_valid"}, 64'(dec_valid), 64'd1);
    check_val({tag, "_dec"},   dec, 64'd0);
    check_val({tag, "_sof"},   64'(dec_sof), 64'd1);
    check_val({tag, "_pm0"},   64'(dut.pm[0]), 64'd0);
    check_val({tag, "_pm32"},  64'(dut.pm[32]), 64'd0);
    check_val({tag, "_pm1"},   64'(dut.pm[1]), 64'd64);
    check_val({tag, "_pm63"},  64'(dut.pm[63]), 64'd64);
    check_val({tag, "_best"},  64'(best_state), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [255:0] cw_bm;
  logic [255:0] b;
  logic [255:0] held_bm;

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    bm_in     = '0;
    in_valid  = 1'b0;
    dec_ready = 1'b1;
    cw_bm     = {{127{2'b10}}, 2'b00};

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid", 64'(dec_valid), 64'd0);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_dec", dec, 64'd0);
    check_val("rst_sof", 64'(dec_sof), 64'd0);
    check_val("rst_best", 64'(best_state), 64'd0);
    check_val("rst_pm1", 64'(dut.pm[1]), 64'd64);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First beat: all metrics zero, explicit start.
    send_beat(1'b1, '0);
    check_zero_restart("first");

    // Noiseless all-zero codeword, back to back.
    for (int i = 0; i < 20; i++) begin
      send_beat(1'b0, cw_bm);
      check_val("cw_valid", 64'(dec_valid), 64'd1);
      check_val("cw_pm0", 64'(dut.pm[0]), 64'd0);
      check_val("cw_dec0", 64'(dec[0]), 64'd0);
      check_val("cw_sof", 64'(dec_sof), 64'd0);
      check_val("cw_best", 64'(best_state), 64'd0);
      if (i == 0) begin
        check_val("cw1_pm16", 64'(dut.pm[16]), 64'd2);
        check_val("cw1_pm32", 64'(dut.pm[32]), 64'd2);
        check_val("cw1_pm48", 64'(dut.pm[48]), 64'd2);
        check_val("cw1_pm1", 64'(dut.pm[1]), 64'd66);
      end
    end
    @(posedge clk);
    #1;
    check_val("drain_valid", 64'(dec_valid), 64'd0);

    // Tie at j=5 (predecessors 10 and 11 both reach 65), then c1 < c0.
    send_beat(1'b1, '0);
    b = put_bm(put_bm('0, 10, 0, 2'd1), 11, 0, 2'd1);
    exp_q.push_back(64'd0);
    send_beat(1'b0, b);
    check_val("tie_dec5", 64'(dec[5]), 64'd0);
    check_val("tie_word", dec, exp_q.pop_front());
    b = put_bm(put_bm('0, 10, 0, 2'd2), 11, 0, 2'd1);
    exp_q.push_back(64'h20);
    send_beat(1'b0, b);
    check_val("pick1_word", dec, exp_q.pop_front());

    // Restart with a minimum of 1 at state 32: exercises normalization.
    b = put_bm(put_bm('0, 0, 0, 2'd2), 0, 1, 2'd1);
    send_beat(1'b1, b);
    check_val("norm_pm0", 64'(dut.pm[0]), 64'd1);
    check_val("norm_pm1", 64'(dut.pm[1]), 64'd63);
    check_val("norm_pm32", 64'(dut.pm[32]), 64'd0);
`ifdef ACS_BEST_STATE_EN
    check_val("norm_best", 64'(best_state), 64'd32);
`else
    check_val("norm_best", 64'(best_state), 64'd0);
`endif
    @(posedge clk);
    #1;

    // Backpressure: word held, input blocked while bm_in changes.
    dec_ready = 1'b0;
    send_beat(1'b1, '0);
    check_val("bp_valid", 64'(dec_valid), 64'd1);
    check_val("bp_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    start    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bm_in = {8{32'($urandom())}};
      @(posedge clk);
      #1;
      check_val("bp_hold_ready", 64'(in_ready), 64'd0);
      check_val("bp_hold_dec", dec, 64'd0);
      check_val("bp_hold_sof", 64'(dec_sof), 64'd1);
      check_val("bp_hold_pm32", 64'(dut.pm[32]), 64'd0);
      check_val("bp_hold_pm1", 64'(dut.pm[1]), 64'd64);
    end
    held_bm   = put_bm(put_bm('0, 10, 0, 2'd2), 11, 0, 2'd1);
    bm_in     = held_bm;
    dec_ready = 1'b1;
    #1;
    check_val("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_val("bp_next_valid", 64'(dec_valid), 64'd1);
    check_val("bp_next_dec", dec, 64'h20);
    check_val("bp_next_sof", 64'(dec_sof), 64'd0);
    @(posedge clk);
    #1;
    check_val("bp_drain_valid", 64'(dec_valid), 64'd0);

    // Saturation on the INIT_PM=255 instance: input-1 metrics all 2.
    send_beat(1'b1, {64{4'b1000}});
    check_val("sat_valid", 64'(s_dec_valid), 64'd1);
    check_val("sat_dec", s_dec, 64'd0);
    check_val("sat_pm0", 64'(dut_sat.pm[0]), 64'd0);
    check_val("sat_pm1", 64'(dut_sat.pm[1]), 64'd255);
    check_val("sat_pm32", 64'(dut_sat.pm[32]), 64'd2);
    check_val("sat_pm33", 64'(dut_sat.pm[33]), 64'd255);

    // Reset between accepted beats.
    send_beat(1'b0, cw_bm);
    send_beat(1'b0, cw_bm);
    check_val("pre_rst_valid", 64'(dec_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", 64'(dec_valid), 64'd0);
    check_val("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(1'b0, '0);
    check_zero_restart("after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
